instr_fetch_queue: RTL
======================

// Module: instr_fetch_queue
// PURPOSE
//  Producer end of the instruction stream consumed by the opcode decoder (ctl).
//  Issues word fetches to instruction memory, buffers in-order responses with their PC,
//  presents {pc, instr} to decode via valid/ready, and flushes/redirects on branch/jump resolve.
// PARAMETERS
//  DEPTH     4             queue entries = max outstanding + buffered instrs (power of 2, >=2)
//  RESET_PC  32'h0000_0000 first fetch address after reset
// PORTS
//  clk             in   1   clock, rising edge
//  rst             in   1   synchronous, active-high reset
//  imem_req_valid  out  1   fetch request valid
//  imem_req_addr   out  32  fetch address, word aligned
//  imem_req_ready  in   1   memory accepts request this cycle
//  imem_rsp_valid  in   1   response valid; in order, exactly one per accepted request, >=1 cycle later
//  imem_rsp_data   in   32  instruction word
//  redirect_valid  in   1   branch/jump taken: flush and refetch
//  redirect_pc     in   32  new fetch PC
//  if_valid        out  1   queue head valid to decode
//  if_ready        in   1   decode consumes head
//  if_instr        out  32  head instruction
//  if_pc           out  32  head PC
//  if_exc          out  1   head is a misaligned-fetch marker (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: imem_req_valid=0, if_valid=0, if_exc=0, if_instr=0, if_pc=0; fetch_pc=rsp_pc=RESET_PC;
//    queue empty; outstanding=0; drop_cnt=0; state RUN. rst wins over every other input.
//  - Issue: imem_req_valid=1 when state RUN, no redirect this cycle, (count+outstanding)<DEPTH.
//    addr=fetch_pc; addr/valid held stable while valid && !ready. Accept -> fetch_pc+=4, outstanding+=1.
//  - Response: outstanding-=1. If drop_cnt>0: discard, drop_cnt-=1. Else push {rsp_pc, data}, rsp_pc+=4.
//    Credit rule guarantees push never hits full queue; push and pop same cycle allowed at any count.
//  - Output: if_* driven from head (registered FIFO, no comb path rsp->if_*). Latency: response in
//    cycle N -> if_valid in N+1. Pop on if_valid && if_ready. Throughput 1 instr/cycle steady state.
//  - Redirect (highest priority after rst): queue flushed (concurrent pop/push ignored);
//    fetch_pc=rsp_pc=redirect_pc; drop_cnt = outstanding after this cycle's accept/response;
//    no request issued in redirect cycle; fetch of redirect_pc starts next cycle.
//  - Response arriving in redirect cycle belongs to old stream: dropped, not counted in drop_cnt.
//  - PC arithmetic mod 2^32; 0xFFFF_FFFC wraps to 0. Counters sized $clog2(DEPTH+1).
// CONFIGURATION
//  FETCH_MISALIGN_CHECK_EN defined: redirect_pc[1:0]!=0 -> state HALT after flush: no requests,
//   queue holds single marker {if_pc=redirect_pc, if_instr=NOP, if_exc=1}; if_valid stays 1 (pop
//   ignored) until next redirect, which returns to RUN (or re-enters HALT if also misaligned).
//   Outstanding responses still drained via drop_cnt while in HALT.
//  Not defined: redirect_pc[1:0] forced to 2'b00; if_exc tied 0; HALT state absent.
// STRUCTURE
//  Package rv32_pkg: XLEN=32, NOP (32'h0000_0013), OPC_* opcode constants shared with ctl,
//   fetch_state_t {RUN, HALT}.
//  Sub-module fetch_fifo: sync FIFO, params WIDTH/DEPTH, push/pop/flush, count, registered head.
//  Top: fetch_pc/rsp_pc regs, outstanding/drop_cnt counters, state FSM, request logic.
// TESTING
//  1. rst 2 cycles, req_ready=1, 1-cycle rsp latency, if_ready=1 -> if_pc 0x0,0x4,0x8.. every cycle, no gaps.
//  2. if_ready=0, DEPTH=4 -> exactly 4 requests accepted, req_valid low; if_ready=1 -> 0x0..0xC in order.
//  3. redirect 0x100 with 2 outstanding -> both rsps discarded, next if_pc=0x100, if_instr=mem[0x100].
//  4. req_ready toggled 1-of-3 cycles -> addr stable while stalled, no duplicate/skipped PCs.
//  5. EN defined: redirect 0x102 -> if_valid=1,if_exc=1,if_pc=0x102,if_instr=NOP, no reqs; redirect 0x200 -> resumes.
//  6. redirect_valid and rst same cycle -> reset state, first fetch addr=RESET_PC.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared RV32 definitions for the fetch queue and the opcode decoder (ctl).
// Holds word size, NOP encoding, major opcode constants, fetch FSM state and queue entry layout.
package rv32_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;  // addi x0, x0, 0

  localparam logic [6:0] OPC_LOAD     = 7'b000_0011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b000_1111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b001_0011;
  localparam logic [6:0] OPC_AUIPC    = 7'b001_0111;
  localparam logic [6:0] OPC_STORE    = 7'b010_0011;
  localparam logic [6:0] OPC_OP       = 7'b011_0011;
  localparam logic [6:0] OPC_LUI      = 7'b011_0111;
  localparam logic [6:0] OPC_BRANCH   = 7'b110_0011;
  localparam logic [6:0] OPC_JALR     = 7'b110_0111;
  localparam logic [6:0] OPC_JAL      = 7'b110_1111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b111_0011;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Sequential PC step; wraps naturally at 2^32.
  function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding fetched {pc, instr} entries; head is read straight from storage
// registers so nothing combinational reaches the consumer from the push side.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [CW-1:0]    count,
  output logic             head_valid,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign head_valid = (count != '0);
  assign do_pop     = pop && head_valid;
  // A push into a full queue is legal only when the head leaves in the same cycle.
  assign do_push    = push && ((count != CW'(DEPTH)) || do_pop);

  // NOTE: storage is deliberately not reset; the head is masked to zero while empty,
  // so stale words can never be observed and the array stays plain flops/RAM.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // NOTE: all state below uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  assign head = head_valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch front end: issues word fetches under a credit limit, queues in-order responses
// with their PC for decode, and flushes/refetches on redirect. Optional FETCH_MISALIGN_CHECK_EN adds HALT.
module instr_fetch_queue
  import rv32_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic            if_exc
);

  localparam int CW = $clog2(DEPTH + 1);

  fetch_state_t    state;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] rsp_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   outstanding_next;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   fifo_count;
  logic [CW:0]     in_flight;
  logic            credit_ok;
  logic            accept;
  logic            push;
  logic            pop;
  logic            head_valid;
  fetch_entry_t    push_entry;
  fetch_entry_t    head_entry;
  logic [XLEN-1:0] redir_pc;
  logic            redir_misaligned;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign redir_pc         = redirect_pc;
  assign redir_misaligned = (redirect_pc[1:0] != 2'b00);
`else
  assign redir_pc         = {redirect_pc[XLEN-1:2], 2'b00};
  assign redir_misaligned = 1'b0;
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];
`endif

  // Every queued entry plus every in-flight request holds one slot, so a response can always be pushed.
  assign in_flight = {1'b0, fifo_count} + {1'b0, outstanding};
  assign credit_ok = (in_flight < (CW + 1)'(DEPTH));

  assign imem_req_valid = !rst && (state == RUN) && !redirect_valid && credit_ok;
  assign imem_req_addr  = fetch_pc;
  assign accept         = imem_req_valid && imem_req_ready;

  assign outstanding_next = outstanding + CW'(accept) - CW'(imem_rsp_valid);

  // Responses in a redirect cycle belong to the old stream and never enter the queue.
  assign push       = imem_rsp_valid && !redirect_valid && (drop_cnt == '0) && (state == RUN);
  assign pop        = if_ready && (state == RUN);
  assign push_entry = '{pc: rsp_pc, instr: imem_rsp_data};

  fetch_fifo #(
    .WIDTH($bits(fetch_entry_t)),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect_valid),
    .count     (fifo_count),
    .head_valid(head_valid),
    .head      (head_entry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding_next;
      if (redirect_valid) begin
        fetch_pc <= redir_pc;
        rsp_pc   <= redir_pc;
        drop_cnt <= outstanding_next;
        state    <= redir_misaligned ? HALT : RUN;
      end else begin
        if (accept) begin
          fetch_pc <= next_pc(fetch_pc);
        end
        if (push) begin
          rsp_pc <= next_pc(rsp_pc);
        end
        if (imem_rsp_valid && (drop_cnt != '0)) begin
          drop_cnt <= drop_cnt - 1'b1;
        end
      end
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  // In HALT the queue is empty and a fixed marker stands in for the head; fetch_pc holds the faulting PC.
  assign if_valid = (state == HALT) || head_valid;
  assign if_pc    = (state == HALT) ? fetch_pc : head_entry.pc;
  assign if_instr = (state == HALT) ? NOP : head_entry.instr;
  assign if_exc   = (state == HALT);
`else
  assign if_valid = head_valid;
  assign if_pc    = head_entry.pc;
  assign if_instr = head_entry.instr;
  assign if_exc   = 1'b0;
`endif

endmodule
